rvga_pipe_ctrl: RTL

//  Parametrised pipeline hazard/forwarding controller. Replaces the fixed hazard + forwarding pair.

---
 rtl/rvga_pipe_ctrl_pkg.sv | 20 ++
 rtl/rvga_pipe_ctrl_if.sv | 39 +++
 rtl/rvga_pipe_ctrl_fwd_pick.sv | 36 +++
 rtl/rvga_pipe_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/rvga_pipe_ctrl_pkg.sv
// Shared types for the rvga pipeline hazard/forwarding controller.
// Default-width register, table-entry and forward-select types, plus the readiness helper.
package rvga_pipe_ctrl_pkg;
  localparam int RVGA_REG_W  = 5;
  localparam int RVGA_STAGES = 4;

  typedef logic [RVGA_REG_W-1:0] rvga_reg;
  typedef struct packed {
    logic    v;
    rvga_reg rd;
    logic    rd_w_v;
    logic    ld_v;
  } rvga_pipe_entry;
  typedef logic [$clog2(RVGA_STAGES+1)-1:0] rvga_fwd_sel;

  // First stage at which a result of this kind can be forwarded.
  function automatic int rdy_stg(input logic ld, input int alu_stg, input int ld_stg);
    return ld ? ld_stg : alu_stg;
  endfunction
endpackage

// File: rtl/rvga_pipe_ctrl_if.sv
// Issue-side handshake bundle between the stage chain and rvga_pipe_ctrl.
interface rvga_pipe_ctrl_if #(
  parameter int STAGES = 4,
  parameter int REG_W  = 5
);
  localparam int SEL_W = $clog2(STAGES+1);

  logic              issue_v_i;
  logic [REG_W-1:0]  issue_rd_i;
  logic              issue_rd_w_v_i;
  logic              issue_ld_v_i;
  logic [REG_W-1:0]  issue_rs1_i;
  logic [REG_W-1:0]  issue_rs2_i;
  logic              issue_rs1_v_i;
  logic              issue_rs2_v_i;
  logic              imem_resp_v_i;
  logic              dmem_req_v_i;
  logic              dmem_resp_v_i;
  logic              flush_i;
  logic              freeze_o;
  logic              issue_accept_o;
  logic              bubble_o;
  logic [SEL_W-1:0]  rs1_fwd_sel_o;
  logic [SEL_W-1:0]  rs2_fwd_sel_o;
  logic [STAGES-1:0] stage_v_o;

  modport master (
    output issue_v_i, issue_rd_i, issue_rd_w_v_i, issue_ld_v_i,
           issue_rs1_i, issue_rs2_i, issue_rs1_v_i, issue_rs2_v_i,
           imem_resp_v_i, dmem_req_v_i, dmem_resp_v_i, flush_i,
    input  freeze_o, issue_accept_o, bubble_o, rs1_fwd_sel_o, rs2_fwd_sel_o, stage_v_o
  );
  modport slave (
    input  issue_v_i, issue_rd_i, issue_rd_w_v_i, issue_ld_v_i,
           issue_rs1_i, issue_rs2_i, issue_rs1_v_i, issue_rs2_v_i,
           imem_resp_v_i, dmem_req_v_i, dmem_resp_v_i, flush_i,
    output freeze_o, issue_accept_o, bubble_o, rs1_fwd_sel_o, rs2_fwd_sel_o, stage_v_o
  );
endinterface

// File: rtl/rvga_pipe_ctrl_fwd_pick.sv
// rvga_fwd_pick: youngest-match / readiness search for one source operand.
module rvga_fwd_pick
  import rvga_pipe_ctrl_pkg::*;
#(
  parameter int STAGES      = 4,
  parameter int REG_W       = 5,
  parameter int ALU_RDY_STG = 1,
  parameter int LD_RDY_STG  = 2,
  parameter int SEL_W       = $clog2(STAGES+1)
) (
  input  logic [STAGES-1:0]            v_i,
  input  logic [STAGES-1:0]            wv_i,
  input  logic [STAGES-1:0]            ld_i,
  input  logic [STAGES-1:0][REG_W-1:0] rd_i,
  input  logic [REG_W-1:0]             rs_i,
  input  logic                         rs_v_i,
  output logic [SEL_W-1:0]             sel_o,
  output logic                         hazard_o
);
  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    sel_o    = '0;
    hazard_o = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (v_i[k-1] && wv_i[k-1] && (rd_i[k-1] == rs_i) && (rs_i != '0) && rs_v_i) begin
        if (k >= rdy_stg(ld_i[k-1], ALU_RDY_STG, LD_RDY_STG)) begin
          sel_o    = SEL_W'(k);
          hazard_o = 1'b0;
        end else begin
          sel_o    = '0;
          hazard_o = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/rvga_pipe_ctrl.sv
// Parametrised hazard/forwarding controller: in-flight rd shift table, freeze/bubble/flush, fwd select.
// Optional RVGA_PIPE_CTRL_PERF_EN adds saturating freeze/bubble/flush event counters.
module rvga_pipe_ctrl
  import rvga_pipe_ctrl_pkg::*;
#(
  parameter int STAGES      = 4,
  parameter int REG_W       = 5,
  parameter int ALU_RDY_STG = 1,
  parameter int LD_RDY_STG  = 2,
  parameter int BR_STG      = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  rvga_pipe_ctrl_if.slave bus
`ifdef RVGA_PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_freeze_cnt_o,
  output logic [31:0] perf_bubble_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);
  localparam int SEL_W = $clog2(STAGES+1);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rd_w_v;
    logic             ld_v;
  } entry_t;

  entry_t [STAGES-1:0] tbl_q, tbl_d;
  entry_t              new_e;
  logic [STAGES-1:0]            v_vec, wv_vec, ld_vec;
  logic [STAGES-1:0][REG_W-1:0] rd_vec;
  logic haz1, haz2, hazard, freeze, accept;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_vec[k]  = tbl_q[k].v;
      wv_vec[k] = tbl_q[k].rd_w_v;
      ld_vec[k] = tbl_q[k].ld_v;
      rd_vec[k] = tbl_q[k].rd;
    end
  end

  rvga_fwd_pick #(.STAGES(STAGES), .REG_W(REG_W), .ALU_RDY_STG(ALU_RDY_STG),
                  .LD_RDY_STG(LD_RDY_STG), .SEL_W(SEL_W)) u_pick_rs1 (
    .v_i(v_vec), .wv_i(wv_vec), .ld_i(ld_vec), .rd_i(rd_vec),
    .rs_i(bus.issue_rs1_i), .rs_v_i(bus.issue_rs1_v_i),
    .sel_o(bus.rs1_fwd_sel_o), .hazard_o(haz1));

  rvga_fwd_pick #(.STAGES(STAGES), .REG_W(REG_W), .ALU_RDY_STG(ALU_RDY_STG),
                  .LD_RDY_STG(LD_RDY_STG), .SEL_W(SEL_W)) u_pick_rs2 (
    .v_i(v_vec), .wv_i(wv_vec), .ld_i(ld_vec), .rd_i(rd_vec),
    .rs_i(bus.issue_rs2_i), .rs_v_i(bus.issue_rs2_v_i),
    .sel_o(bus.rs2_fwd_sel_o), .hazard_o(haz2));

  assign hazard = haz1 | haz2;
  assign freeze = ~bus.imem_resp_v_i | (bus.dmem_req_v_i & ~bus.dmem_resp_v_i);
  assign accept = bus.issue_v_i & ~hazard & ~freeze & ~bus.flush_i;

  assign bus.freeze_o       = freeze;
  assign bus.issue_accept_o = accept;
  assign bus.bubble_o       = bus.issue_v_i & hazard & ~freeze & ~bus.flush_i;
  assign bus.stage_v_o      = v_vec;

  always_comb begin
    new_e = '0;
    if (accept) new_e = '{v: 1'b1, rd: bus.issue_rd_i, rd_w_v: bus.issue_rd_w_v_i,
                          ld_v: bus.issue_ld_v_i};
    tbl_d = tbl_q;
    if (!freeze) begin
      tbl_d[0] = new_e;
      for (int k = 1; k < STAGES; k++) tbl_d[k] = tbl_q[k-1];
      // Everything younger than the branch has moved up to BR_STG or below: kill it.
      if (bus.flush_i)
        for (int k = 0; k < STAGES; k++)
          if (k < BR_STG) tbl_d[k].v = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tbl_q <= '0;
    else        tbl_q <= tbl_d;
  end

`ifdef RVGA_PIPE_CTRL_PERF_EN
  logic [31:0] frz_cnt_q, bub_cnt_q, fl_cnt_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frz_cnt_q <= '0;
      bub_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      if (freeze && ~&frz_cnt_q)                 frz_cnt_q <= frz_cnt_q + 32'd1;
      if (bus.bubble_o && ~&bub_cnt_q)           bub_cnt_q <= bub_cnt_q + 32'd1;
      if (bus.flush_i && !freeze && ~&fl_cnt_q)  fl_cnt_q  <= fl_cnt_q + 32'd1;
    end
  end
  assign perf_freeze_cnt_o = frz_cnt_q;
  assign perf_bubble_cnt_o = bub_cnt_q;
  assign perf_flush_cnt_o  = fl_cnt_q;
`endif
endmodule
